// File: rtl/decim_stream_fifo_pkg.sv
// Shared defaults for the decimator sample path: widths and FIFO depth helper.
package decim_stream_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LOG2_DEPTH = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  // Number of FIFO entries for a given log2 depth.
  function automatic int depth_of(input int log2_depth);
    return 32'sd1 << log2_depth;
  endfunction

endpackage

// File: rtl/decim_stream_fifo_if.sv
// Sample-in / stream-out / drop-status bundle between decimator, FIFO and consumer.
interface decim_stream_fifo_if
  import decim_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_flag;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LOG2_DEPTH:0]     level;
  logic                    overflow;
  logic [CNT_WIDTH-1:0]    drop_count;
  logic                    clear_overflow;

  // Producer/consumer side driving the FIFO.
  modport master (
    output in_data, in_flag, out_ready, clear_overflow,
    input  out_data, out_valid, level, overflow, drop_count
  );

  // The FIFO itself.
  modport slave (
    input  in_data, in_flag, out_ready, clear_overflow,
    output out_data, out_valid, level, overflow, drop_count
  );
endinterface

// File: rtl/decim_stream_fifo_mem.sv
// Simple dual-port register array: registered write, asynchronous read.
module decim_stream_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Storage write; contents need no reset since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/decim_stream_fifo.sv
// Captures strobed decimated samples into a FWFT FIFO, re-presents them on a
// valid/ready stream, and counts samples dropped while the FIFO is full.
module decim_stream_fifo
  import decim_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  decim_stream_fifo_if.slave bus
);
  localparam int DEPTH = depth_of(LOG2_DEPTH);

  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_DEPTH-1:0] r_rd_ptr;
  logic [LOG2_DEPTH:0]   r_level;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_drop_count;

  logic                  w_valid;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_valid = (r_level != {(LOG2_DEPTH+1){1'b0}});
  assign w_full  = (r_level == (LOG2_DEPTH+1)'(DEPTH));
  assign w_pop   = w_valid & bus.out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign w_push  = bus.in_flag & (~w_full | w_pop);
  assign w_drop  = bus.in_flag & w_full & ~w_pop;

  decim_stream_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(LOG2_DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {LOG2_DEPTH{1'b0}};
      r_rd_ptr <= {LOG2_DEPTH{1'b0}};
      r_level  <= {(LOG2_DEPTH+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LOG2_DEPTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (LOG2_DEPTH+1)'(1);
        2'b01:   r_level <= r_level - (LOG2_DEPTH+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= {CNT_WIDTH{1'b0}};
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (bus.clear_overflow) begin
        r_drop_count <= CNT_WIDTH'(1);
      end else if (r_drop_count != {CNT_WIDTH{1'b1}}) begin
        r_drop_count <= r_drop_count + CNT_WIDTH'(1);
      end else begin
        r_drop_count <= r_drop_count;
      end
    end else if (bus.clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= {CNT_WIDTH{1'b0}};
    end else begin
      r_overflow   <= r_overflow;
      r_drop_count <= r_drop_count;
    end
  end

  // Head data is forced to zero while empty so reset shows a clean bus.
  assign bus.out_data   = w_valid ? w_rdata : {DATA_WIDTH{1'b0}};
  assign bus.out_valid  = w_valid;
  assign bus.level      = r_level;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_decim_stream_fifo.sv
// Self-checking bench for decim_stream_fifo with a 16-deep FIFO and 4-bit drop counter.
module tb_decim_stream_fifo;
  localparam int DW    = 32;
  localparam int L2D   = 4;
  localparam int CW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] e;

  decim_stream_fifo_if #(.DATA_WIDTH(DW), .LOG2_DEPTH(L2D), .CNT_WIDTH(CW)) bus ();

  decim_stream_fifo #(.DATA_WIDTH(DW), .LOG2_DEPTH(L2D), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 32'd0) begin bad++; $display("FAIL rst_data got=%0h exp=0", bus.out_data); end
    total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", bus.level); end
    total++; if (bus.overflow !== 1'b0 || bus.drop_count !== 4'd0) begin
      bad++; $display("FAIL rst_ovf got=%0d/%0d exp=0/0", bus.overflow, bus.drop_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.in_data = -32'sd5; bus.in_flag = 1'b1;
    exp_q.push_back(-32'sd5);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_no_passthru got=%0d exp=0", bus.out_valid); end
    tick();
    bus.in_flag = 1'b0;
    e = exp_q.pop_front();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
      bad++; $display("FAIL single_out got=%0d/%0d exp=1/%0d", bus.out_valid, $signed(bus.out_data), $signed(e));
    end
    total++; if (bus.level !== 5'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", bus.level); end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.level !== 5'd0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL single_pop got=%0d/%0d exp=0/0", bus.level, bus.out_valid);
    end
    // out_ready while empty must not move pointers
    tick();
    bus.out_ready = 1'b0;
    bus.in_data = -32'sd7; bus.in_flag = 1'b1;
    exp_q.push_back(-32'sd7);
    tick();
    bus.in_flag = 1'b0;
    e = exp_q.pop_front();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.level !== 5'd1) begin
      bad++; $display("FAIL empty_ready got=%0d/%0d/%0d exp=1/%0d/1", bus.out_valid, $signed(bus.out_data), bus.level, $signed(e));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DEPTH; i++) begin
      bus.in_data = DW'(i); bus.in_flag = 1'b1;
      exp_q.push_back(DW'(i));
      tick();
    end
    bus.in_flag = 1'b0;
    total++; if (bus.level !== 5'd16 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL fill_level got=%0d/%0d exp=16/0", bus.level, bus.overflow);
    end
    for (int i = 100; i <= 102; i++) begin
      bus.in_data = DW'(i); bus.in_flag = 1'b1;
      tick();
    end
    bus.in_flag = 1'b0;
    total++; if (bus.overflow !== 1'b1 || bus.drop_count !== 4'd3) begin
      bad++; $display("FAIL ovf_count got=%0d/%0d exp=1/3", bus.overflow, bus.drop_count);
    end
    total++; if (bus.out_data !== exp_q[0] || bus.level !== 5'd16) begin
      bad++; $display("FAIL ovf_head got=%0d/%0d exp=%0d/16", bus.out_data, bus.level, exp_q[0]);
    end
  endtask

  task automatic test_full_push_pop();
    bus.in_data = 32'd77; bus.in_flag = 1'b1; bus.out_ready = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(32'd77);
    tick();
    bus.in_flag = 1'b0;
    total++; if (bus.level !== 5'd16 || bus.drop_count !== 4'd3 || bus.out_data !== exp_q[0]) begin
      bad++; $display("FAIL full_pushpop got=%0d/%0d/%0d exp=16/3/%0d", bus.level, bus.drop_count, bus.out_data, exp_q[0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
        bad++; $display("FAIL drain_%0d got=%0d/%0d exp=1/%0d", i, bus.out_valid, bus.out_data, e);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    total++; if (bus.level !== 5'd0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_empty got=%0d/%0d exp=0/0", bus.level, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
          bad++; $display("FAIL b2b_%0d got=%0d/%0d exp=1/%0d", i, bus.out_valid, $signed(bus.out_data), $signed(e));
        end
      end
      bus.in_data = DW'(-1000 - i); bus.in_flag = 1'b1;
      exp_q.push_back(DW'(-1000 - i));
      tick();
      total++; if (bus.level !== 5'd1) begin bad++; $display("FAIL b2b_level_%0d got=%0d exp=1", i, bus.level); end
    end
    bus.in_flag = 1'b0;
    e = exp_q.pop_front();
    total++; if (bus.out_data !== e) begin bad++; $display("FAIL b2b_last got=%0d exp=%0d", $signed(bus.out_data), $signed(e)); end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_clear_race();
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    total++; if (bus.overflow !== 1'b0 || bus.drop_count !== 4'd0) begin
      bad++; $display("FAIL clear_alone got=%0d/%0d exp=0/0", bus.overflow, bus.drop_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_data = DW'(200 + i); bus.in_flag = 1'b1;
      exp_q.push_back(DW'(200 + i));
      tick();
    end
    bus.in_data = 32'd300; bus.clear_overflow = 1'b1;
    tick();
    bus.in_flag = 1'b0; bus.clear_overflow = 1'b0;
    total++; if (bus.overflow !== 1'b1 || bus.drop_count !== 4'd1 || bus.level !== 5'd16) begin
      bad++; $display("FAIL clear_race got=%0d/%0d/%0d exp=1/1/16", bus.overflow, bus.drop_count, bus.level);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      bus.in_data = DW'(400 + i); bus.in_flag = 1'b1;
      tick();
      if (i == 13) begin
        total++; if (bus.drop_count !== 4'd15) begin bad++; $display("FAIL sat_reach got=%0d exp=15", bus.drop_count); end
      end
    end
    bus.in_flag = 1'b0;
    total++; if (bus.drop_count !== 4'd15 || bus.overflow !== 1'b1) begin
      bad++; $display("FAIL sat_hold got=%0d/%0d exp=15/1", bus.drop_count, bus.overflow);
    end
    total++; if (bus.out_data !== exp_q[0]) begin bad++; $display("FAIL sat_head got=%0d exp=%0d", bus.out_data, exp_q[0]); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.level !== 5'd0) begin
      bad++; $display("FAIL arst_fifo got=%0d/%0d/%0d exp=0/0/0", bus.out_valid, bus.out_data, bus.level);
    end
    total++; if (bus.overflow !== 1'b0 || bus.drop_count !== 4'd0) begin
      bad++; $display("FAIL arst_ovf got=%0d/%0d exp=0/0", bus.overflow, bus.drop_count);
    end
    #2;
    rst_n = 1'b1;
    tick();
    bus.in_data = 32'h8000_0001; bus.in_flag = 1'b1;
    exp_q.push_back(32'h8000_0001);
    tick();
    bus.in_flag = 1'b0;
    e = exp_q.pop_front();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.level !== 5'd1) begin
      bad++; $display("FAIL arst_restart got=%0d/%0h/%0d exp=1/%0h/1", bus.out_valid, bus.out_data, bus.level, e);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.in_data = 32'd0; bus.in_flag = 1'b0;
    bus.out_ready = 1'b0; bus.clear_overflow = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clear_race();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
